background_scroll_mapper: RTL and testbench

BACKGROUND_SCROLL_MAPPER -- requirements
Module: background_scroll_mapper

---
 rtl/background_scroll_mapper_if.sv | 33 +++
 rtl/background_scroll_mapper.sv | 116 +++++++++++
 tb/tb_background_scroll_mapper.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/background_scroll_mapper_if.sv
// Pixel-stream, scroll, palette and ROM signals shared by the background scroll mapper.
interface background_scroll_mapper_if #(
    parameter int unsigned PIX_BITS = 2,
    parameter int unsigned ADDR_W   = 19
);
    logic [9:0]          DrawX;
    logic [9:0]          DrawY;
    logic                frame_start;
    logic [9:0]          scroll_in;
    logic                scroll_wr;
    logic                pal_we;
    logic [PIX_BITS-1:0] pal_idx;
    logic [23:0]         pal_rgb;
    logic [ADDR_W-1:0]   rom_addr;
    logic [PIX_BITS-1:0] rom_data;
    logic [7:0]          Red;
    logic [7:0]          Green;
    logic [7:0]          Blue;
    logic                bg_on;
    logic                scroll_err;

    modport slave (
        input  DrawX, DrawY, frame_start, scroll_in, scroll_wr,
        input  pal_we, pal_idx, pal_rgb, rom_data,
        output rom_addr, Red, Green, Blue, bg_on, scroll_err
    );

    modport master (
        output DrawX, DrawY, frame_start, scroll_in, scroll_wr,
        output pal_we, pal_idx, pal_rgb, rom_data,
        input  rom_addr, Red, Green, Blue, bg_on, scroll_err
    );
endinterface

// File: rtl/background_scroll_mapper.sv
// Maps VGA coordinates to a vertically scrolling background ROM and colours the
// returned pixel index through a register palette.
module background_scroll_mapper #(
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned IMG_H    = 480,
    parameter int unsigned ORG_X    = 0,
    parameter int unsigned ORG_Y    = 0,
    parameter int unsigned WIN_W    = 640,
    parameter int unsigned WIN_H    = 480,
    parameter int unsigned PIX_BITS = 2,
    parameter int unsigned ROM_LAT  = 1,
    parameter int unsigned ADDR_W   = 19
) (
    input logic                         clk,
    input logic                         Reset_n,
    background_scroll_mapper_if.slave   bus
);
    localparam int unsigned CW    = 12;
    localparam int unsigned SW    = 10;
    localparam int unsigned PAL_N = 1 << PIX_BITS;

    logic [CW-1:0]     w_x, w_y, w_row_sum, w_row, w_col;
    logic              w_in_win;
    logic              w_wr_ok;
    logic              w_wr_rej;
    logic [ADDR_W-1:0] w_addr;

    logic [SW-1:0]     r_scroll_cur;
    logic [SW-1:0]     r_pending;
    logic              r_pend_v;
    logic              r_scroll_err;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [ROM_LAT:0]  r_win_pipe;
    logic [23:0]       r_pal [PAL_N];
    logic [7:0]        r_red, r_green, r_blue;
    logic              r_bg_on;

    // Window test and wrapped row/column, kept wide so nothing truncates before the compare
    assign w_x       = CW'(bus.DrawX);
    assign w_y       = CW'(bus.DrawY);
    assign w_in_win  = (w_x >= CW'(ORG_X)) && (w_x < CW'(ORG_X + WIN_W)) &&
                       (w_y >= CW'(ORG_Y)) && (w_y < CW'(ORG_Y + WIN_H));
    assign w_row_sum = (w_y - CW'(ORG_Y)) + CW'(r_scroll_cur);
    assign w_row     = (w_row_sum >= CW'(IMG_H)) ? (w_row_sum - CW'(IMG_H)) : w_row_sum;
    assign w_col     = w_x - CW'(ORG_X);
    assign w_addr    = ADDR_W'(w_row) * ADDR_W'(IMG_W) + ADDR_W'(w_col);

    assign w_wr_ok   = bus.scroll_wr && (CW'(bus.scroll_in) < CW'(IMG_H));
    assign w_wr_rej  = bus.scroll_wr && !w_wr_ok;

    // Scroll offset only moves at frame_start; a same-cycle valid write bypasses pending
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_scroll_cur <= '0;
            r_pending    <= '0;
            r_pend_v     <= 1'b0;
            r_scroll_err <= 1'b0;
        end else begin
            if (w_wr_rej) r_scroll_err <= 1'b1;
            if (bus.frame_start) begin
                if (w_wr_ok)       r_scroll_cur <= bus.scroll_in;
                else if (r_pend_v) r_scroll_cur <= r_pending;
                r_pend_v <= 1'b0;
            end else if (w_wr_ok) begin
                r_pending <= bus.scroll_in;
                r_pend_v  <= 1'b1;
            end
        end
    end

    // ROM address holds outside the window; in_win travels alongside the ROM latency
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr <= '0;
            r_win_pipe <= '0;
        end else begin
            if (w_in_win) r_rom_addr <= w_addr;
            r_win_pipe <= {r_win_pipe[ROM_LAT-1:0], w_in_win};
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(PAL_N); i++) begin
                r_pal[i] <= (i == 0) ? 24'hFFFFFF : ((i == 1) ? 24'hFFA500 : 24'h000000);
            end
        end else if (bus.pal_we) begin
            r_pal[bus.pal_idx] <= bus.pal_rgb;
        end
    end

    // Palette is read before any same-cycle write lands, so a collision returns the old entry
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_bg_on <= 1'b0;
        end else if (r_win_pipe[ROM_LAT]) begin
            {r_red, r_green, r_blue} <= r_pal[bus.rom_data];
            r_bg_on <= 1'b1;
        end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_bg_on <= 1'b0;
        end
    end

    assign bus.rom_addr   = r_rom_addr;
    assign bus.Red        = r_red;
    assign bus.Green      = r_green;
    assign bus.Blue       = r_blue;
    assign bus.bg_on      = r_bg_on;
    assign bus.scroll_err = r_scroll_err;
endmodule

// File: tb/tb_background_scroll_mapper.sv
// Self-checking bench: a full-screen instance and an offset window instance with ROM_LAT=2
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_background_scroll_mapper;
    localparam int IMG_W = 640;
    localparam int IMG_H = 480;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  x, y, sin;
    logic        fs, swr, pwe;
    logic [1:0]  pidx;
    logic [23:0] prgb;
    logic [1:0]  rom0, rom1a, rom1b;

    always #5 clk = ~clk;

    background_scroll_mapper_if #(.PIX_BITS(2), .ADDR_W(19)) bus0 ();
    background_scroll_mapper_if #(.PIX_BITS(2), .ADDR_W(19)) bus1 ();

    assign bus0.DrawX = x;    assign bus1.DrawX = x;
    assign bus0.DrawY = y;    assign bus1.DrawY = y;
    assign bus0.frame_start = fs;  assign bus1.frame_start = fs;
    assign bus0.scroll_in = sin;   assign bus1.scroll_in = sin;
    assign bus0.scroll_wr = swr;   assign bus1.scroll_wr = swr;
    assign bus0.pal_we = pwe;      assign bus1.pal_we = pwe;
    assign bus0.pal_idx = pidx;    assign bus1.pal_idx = pidx;
    assign bus0.pal_rgb = prgb;    assign bus1.pal_rgb = prgb;
    assign bus0.rom_data = rom0;
    assign bus1.rom_data = rom1b;

    function automatic logic [1:0] pix(input logic [18:0] a);
        return a[1:0] ^ a[5:4];
    endfunction

    // Background ROM models: one and two clocks of read latency
    always @(posedge clk) begin
        rom0  <= pix(bus0.rom_addr);
        rom1a <= pix(bus1.rom_addr);
        rom1b <= rom1a;
    end

    background_scroll_mapper dut0 (.clk(clk), .Reset_n(rst_n), .bus(bus0.slave));
    background_scroll_mapper #(.ORG_X(100), .ORG_Y(50), .WIN_W(200), .WIN_H(100), .ROM_LAT(2))
        dut1 (.clk(clk), .Reset_n(rst_n), .bus(bus1.slave));

    function automatic int ox(input int d);  return (d == 0) ? 0   : 100; endfunction
    function automatic int oy(input int d);  return (d == 0) ? 0   : 50;  endfunction
    function automatic int ww(input int d);  return (d == 0) ? 640 : 200; endfunction
    function automatic int wh(input int d);  return (d == 0) ? 480 : 100; endfunction
    function automatic int lat(input int d); return (d == 0) ? 1   : 2;   endfunction

    int          checks, errors;
    int          m_cur, m_pend;
    bit          m_pv, m_err;
    logic [23:0] m_pal [4];
    int          m_addr [2];
    logic [23:0] e_rgb [2];
    bit          e_on [2];

    typedef struct { bit win; int addr; } rec_t;
    rec_t q0[$], q1[$];

    typedef struct { int s; int xx; int yy; int addr; bit on; } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input int d, input int xx, input int yy);
        return xx >= ox(d) && xx < ox(d) + ww(d) && yy >= oy(d) && yy < oy(d) + wh(d);
    endfunction

    function automatic int calc_addr(input int d, input int xx, input int yy);
        return ((yy - oy(d) + m_cur) % IMG_H) * IMG_W + (xx - ox(d));
    endfunction

    task automatic model_reset();
        rec_t z;
        z.win = 1'b0; z.addr = 0;
        m_cur = 0; m_pend = 0; m_pv = 1'b0; m_err = 1'b0;
        m_pal[0] = 24'hFFFFFF; m_pal[1] = 24'hFFA500; m_pal[2] = 24'h0; m_pal[3] = 24'h0;
        m_addr[0] = 0; m_addr[1] = 0;
        q0.delete(); q1.delete();
        for (int i = 0; i <= lat(0); i++) q0.push_back(z);
        for (int i = 0; i <= lat(1); i++) q1.push_back(z);
    endtask

    // One clock: predict from current inputs, advance the model, then compare both DUTs
    task automatic cycle();
        rec_t r, o;
        bool_ok: begin end
        for (int d = 0; d < 2; d++) begin
            r.win = in_win(d, int'(x), int'(y));
            if (r.win) m_addr[d] = calc_addr(d, int'(x), int'(y));
            r.addr = m_addr[d];
            if (d == 0) begin q0.push_back(r); o = q0.pop_front(); end
            else        begin q1.push_back(r); o = q1.pop_front(); end
            e_on[d]  = o.win;
            e_rgb[d] = o.win ? m_pal[pix(19'(o.addr))] : 24'h0;
        end
        if (pwe) m_pal[pidx] = prgb;
        if (swr && int'(sin) >= IMG_H) m_err = 1'b1;
        if (fs) begin
            if (swr && int'(sin) < IMG_H) m_cur = int'(sin);
            else if (m_pv)                m_cur = m_pend;
            m_pv = 1'b0;
        end else if (swr && int'(sin) < IMG_H) begin
            m_pend = int'(sin);
            m_pv   = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("addr0", int'(bus0.rom_addr), m_addr[0]);
        chk("rgb0",  int'({bus0.Red, bus0.Green, bus0.Blue}), int'(e_rgb[0]));
        chk("on0",   int'(bus0.bg_on), int'(e_on[0]));
        chk("err0",  int'(bus0.scroll_err), int'(m_err));
        chk("addr1", int'(bus1.rom_addr), m_addr[1]);
        chk("rgb1",  int'({bus1.Red, bus1.Green, bus1.Blue}), int'(e_rgb[1]));
        chk("on1",   int'(bus1.bg_on), int'(e_on[1]));
        chk("err1",  int'(bus1.scroll_err), int'(m_err));
    endtask

    task automatic quiet();
        swr = 1'b0; fs = 1'b0; pwe = 1'b0;
    endtask

    task automatic park();
        x = 10'd1023; y = 10'd1023;
    endtask

    // Load a scroll value immediately through the same-cycle bypass
    task automatic set_scroll(input int s);
        park(); sin = 10'(s); swr = 1'b1; fs = 1'b1;
        cycle();
        quiet();
    endtask

    task automatic pixel(input int xx, input int yy);
        x = 10'(xx); y = 10'(yy);
        cycle();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; park(); sin = '0; quiet(); pidx = '0; prgb = '0;
        model_reset();
        tbl[0] = '{0,   5,   0,   5,      1'b1};
        tbl[1] = '{470, 0,   20,  6400,   1'b1};
        tbl[2] = '{7,   0,   0,   4480,   1'b1};
        tbl[3] = '{479, 639, 479, 306559, 1'b1};
        tbl[4] = '{0,   640, 0,   306559, 1'b0};
        tbl[5] = '{1,   0,   479, 0,      1'b1};
        tbl[6] = '{0,   0,   480, 0,      1'b0};
        tbl[7] = '{200, 10,  300, 12810,  1'b1};

        repeat (3) @(negedge clk);
        chk("rst_addr", int'(bus0.rom_addr), 0);
        chk("rst_rgb",  int'({bus0.Red, bus0.Green, bus0.Blue}), 0);
        chk("rst_on",   int'(bus0.bg_on), 0);
        chk("rst_err",  int'(bus0.scroll_err), 0);
        rst_n = 1'b1;

        // Latency: address after one clock, colour exactly three clocks after the input
        set_scroll(0);
        pixel(5, 0);
        chk("lat_addr", int'(bus0.rom_addr), 5);
        park(); cycle();
        chk("lat_early", int'(bus0.bg_on), 0);
        cycle();
        chk("lat_rgb", int'({bus0.Red, bus0.Green, bus0.Blue}), 32'hFFA500);
        chk("lat_on",  int'(bus0.bg_on), 1);

        for (int i = 0; i < 8; i++) begin
            set_scroll(tbl[i].s);
            pixel(tbl[i].xx, tbl[i].yy);
            chk("tbl_addr", int'(bus0.rom_addr), tbl[i].addr);
            park(); cycle(); cycle();
            chk("tbl_on", int'(bus0.bg_on), int'(tbl[i].on));
        end

        // Bypass leaves nothing pending: a later bare frame_start keeps row 7
        set_scroll(7);
        park(); fs = 1'b1; cycle(); quiet();
        pixel(0, 0);
        chk("bypass_keep", int'(bus0.rom_addr), 4480);

        // Deferred write, rejected write, then application at frame_start
        set_scroll(0);
        park(); sin = 10'd100; swr = 1'b1; cycle(); quiet();
        pixel(0, 0);
        chk("defer_addr", int'(bus0.rom_addr), 0);
        park(); sin = 10'd480; swr = 1'b1; cycle(); quiet();
        chk("reject_err", int'(bus0.scroll_err), 1);
        pixel(0, 0);
        chk("reject_addr", int'(bus0.rom_addr), 0);
        park(); fs = 1'b1; cycle(); quiet();
        pixel(0, 0);
        chk("defer_apply", int'(bus0.rom_addr), 64000);

        // Last valid write in a frame wins
        park(); sin = 10'd3; swr = 1'b1; cycle();
        sin = 10'd9; cycle(); quiet();
        fs = 1'b1; cycle(); quiet();
        pixel(0, 0);
        chk("last_wins", int'(bus0.rom_addr), 5760);

        // Offset window edge on the second instance
        set_scroll(0);
        pixel(99, 60);
        pixel(100, 60);
        park(); cycle(); cycle();
        chk("win_left_on",  int'(bus1.bg_on), 0);
        chk("win_left_rgb", int'({bus1.Red, bus1.Green, bus1.Blue}), 0);
        cycle();
        chk("win_in_on", int'(bus1.bg_on), 1);

        // Palette rewrite shows on the next pixel using that entry
        park(); pwe = 1'b1; pidx = 2'd1; prgb = 24'h00FF00; cycle(); quiet();
        pixel(5, 0);
        park(); cycle(); cycle();
        chk("pal_green", int'({bus0.Red, bus0.Green, bus0.Blue}), 32'h00FF00);

        // Mid-frame reset clears outputs at once and restores the palette
        for (int i = 0; i < 4; i++) pixel(5, 0);
        chk("pre_rst_on", int'(bus0.bg_on), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_on",  int'(bus0.bg_on), 0);
        chk("rst_mid_rgb", int'({bus0.Red, bus0.Green, bus0.Blue}), 0);
        chk("rst_mid_addr", int'(bus0.rom_addr), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pixel(5, 0);
        park(); cycle();
        chk("post_rst_early", int'(bus0.bg_on), 0);
        cycle();
        chk("pal_restored", int'({bus0.Red, bus0.Green, bus0.Blue}), 32'hFFA500);

        // Randomized traffic, biased towards both windows and the wrap rows
        for (int n = 0; n < 3000; n++) begin
            x    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(90, 320));
            y    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                 : (($urandom_range(0, 1) == 0) ? 10'($urandom_range(40, 170)) : 10'($urandom_range(460, 490)));
            swr  = ($urandom_range(0, 9) == 0);
            sin  = 10'($urandom_range(0, 520));
            fs   = ($urandom_range(0, 39) == 0);
            pwe  = ($urandom_range(0, 15) == 0);
            pidx = 2'($urandom_range(0, 3));
            prgb = 24'($urandom);
            cycle();
        end
        quiet();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
